// File: rtl/axi_mem_responder_pkg.sv
// axi_mem_responder_pkg
//   Shared definitions for the AXI4 memory responder: response codes and
//   the write/read FSM state encodings.
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_mem_bank.sv
// axi_mem_bank
//   Simple dual-port RAM: one byte-enable write port, one read port with a
//   single cycle of registered latency. Contents are not reset. A read and a
//   write to the same word in the same cycle return the old contents.
//
//   clk      clock
//   wr_en    write enable
//   wr_addr  write word index
//   wr_strb  per-byte write enables
//   wr_data  write data
//   rd_en    read enable; rd_data updates only when asserted
//   rd_addr  read word index
//   rd_data  registered read data, held between reads
module axi_mem_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave endpoint backed by an internal byte-enable RAM. Independent
//   write and read FSMs, one outstanding transaction per direction, full-width
//   INCR bursts only.
//
//   Build option: AXI_MEM_RESPONDER_PREFETCH_EN
//     defined   - the next read beat is fetched while the current beat is
//                 being accepted, giving 1 beat/cycle with r_ready held high.
//     undefined - each read beat costs a fetch cycle (1 beat per 2 cycles).
//
//   Ports
//     clk_i, rst_i           clock, synchronous active-high reset
//     axi_slave_aw_*         write address channel (valid/addr/len/id/ready)
//     axi_slave_w_*          write data channel (valid/data/strb/last/ready)
//     axi_slave_b_*          write response channel (valid/resp/id/ready)
//     axi_slave_ar_*         read address channel (valid/addr/len/id/ready)
//     axi_slave_r_*          read data channel (valid/data/resp/last/id/ready)
//
//   Write FSM
//     state   | meaning
//     W_IDLE  | aw_ready high, waiting for a write address
//     W_DATA  | w_ready high, accepting beats until w_last
//     W_RESP  | b_valid high until b_ready
//
//   Read FSM
//     state   | meaning
//     R_IDLE  | ar_ready high, waiting for a read address
//     R_FETCH | RAM read of the current beat in flight
//     R_DATA  | r_valid high, beat held until r_ready
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        axi_slave_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
    input  logic [7:0]                  axi_slave_aw_len_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
    output logic                        axi_slave_aw_ready_o,

    input  logic                        axi_slave_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
    input  logic                        axi_slave_w_last_i,
    output logic                        axi_slave_w_ready_o,

    output logic                        axi_slave_b_valid_o,
    output logic [1:0]                  axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id_o,
    input  logic                        axi_slave_b_ready_i,

    input  logic                        axi_slave_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr_i,
    input  logic [7:0]                  axi_slave_ar_len_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id_i,
    output logic                        axi_slave_ar_ready_o,

    output logic                        axi_slave_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data_o,
    output logic [1:0]                  axi_slave_r_resp_o,
    output logic                        axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id_o,
    input  logic                        axi_slave_r_ready_i
);

    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int OFF_W          = $clog2(AXI_STRB_WIDTH);
    localparam int IDX_W          = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_STRB_WIDTH);

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    // Any address bit above the word index selects memory that does not exist.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >> (OFF_W + IDX_W)) != '0;
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t                 w_state;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [7:0]                w_len;
    logic [8:0]                w_cnt;
    logic                      w_slverr;
    logic                      w_decerr;

    logic w_fire;
    logic w_keep;
    logic w_dec_now;
    logic w_slv_now;
    logic bank_wr_en;

    assign w_fire    = axi_slave_w_valid_i & axi_slave_w_ready_o;
    // Beats past len are dropped; the counter stops at len+1.
    assign w_keep    = w_cnt <= {1'b0, w_len};
    assign w_dec_now = w_keep & out_of_range(w_addr);
    assign w_slv_now = axi_slave_w_last_i ? (w_cnt != {1'b0, w_len})
                                          : (w_cnt == {1'b0, w_len});
    assign bank_wr_en = w_fire & w_keep & ~out_of_range(w_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state              <= W_IDLE;
            w_addr               <= '0;
            w_len                <= '0;
            w_cnt                <= '0;
            w_slverr             <= 1'b0;
            w_decerr             <= 1'b0;
            axi_slave_aw_ready_o <= 1'b0;
            axi_slave_w_ready_o  <= 1'b0;
            axi_slave_b_valid_o  <= 1'b0;
            axi_slave_b_resp_o   <= RESP_OKAY;
            axi_slave_b_id_o     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_slave_aw_valid_i && axi_slave_aw_ready_o) begin
                        w_addr               <= axi_slave_aw_addr_i;
                        w_len                <= axi_slave_aw_len_i;
                        w_cnt                <= '0;
                        w_slverr             <= 1'b0;
                        w_decerr             <= 1'b0;
                        axi_slave_b_id_o     <= axi_slave_aw_id_i;
                        axi_slave_aw_ready_o <= 1'b0;
                        axi_slave_w_ready_o  <= 1'b1;
                        w_state              <= W_DATA;
                    end else begin
                        axi_slave_aw_ready_o <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_keep) begin
                            w_cnt  <= w_cnt + 9'd1;
                            w_addr <= w_addr + BEAT_BYTES;
                        end
                        if (w_dec_now) w_decerr <= 1'b1;
                        if (w_slv_now) w_slverr <= 1'b1;
                        if (axi_slave_w_last_i) begin
                            axi_slave_w_ready_o <= 1'b0;
                            axi_slave_b_valid_o <= 1'b1;
                            if (w_decerr || w_dec_now)
                                axi_slave_b_resp_o <= RESP_DECERR;
                            else if (w_slverr || w_slv_now)
                                axi_slave_b_resp_o <= RESP_SLVERR;
                            else
                                axi_slave_b_resp_o <= RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_slave_b_ready_i) begin
                        axi_slave_b_valid_o  <= 1'b0;
                        axi_slave_b_resp_o   <= RESP_OKAY;
                        axi_slave_aw_ready_o <= 1'b1;
                        w_state              <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t                 r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [7:0]                r_beat;
    logic                      r_data_en;

    logic                      r_fire;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_nxt;
    logic [7:0]                r_beat_nxt;
    logic                      bank_rd_en;
    logic [IDX_W-1:0]          bank_rd_addr;
    logic [AXI_DATA_WIDTH-1:0] bank_rd_data;

    assign r_fire     = axi_slave_r_valid_o & axi_slave_r_ready_i;
    assign r_addr_nxt = r_addr + BEAT_BYTES;
    assign r_beat_nxt = r_beat + 8'd1;

`ifdef AXI_MEM_RESPONDER_PREFETCH_EN
    // The next beat is read only on the accepting handshake, so the bank's
    // output register keeps the presented beat stable while r_ready is low.
    assign bank_rd_en   = (r_state == R_FETCH) | (r_fire & ~axi_slave_r_last_o);
    assign bank_rd_addr = (r_state == R_FETCH) ? word_idx(r_addr) : word_idx(r_addr_nxt);
`else
    assign bank_rd_en   = (r_state == R_FETCH);
    assign bank_rd_addr = word_idx(r_addr);
`endif

    // Out-of-range beats and idle cycles present zero data.
    assign axi_slave_r_data_o = r_data_en ? bank_rd_data : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state              <= R_IDLE;
            r_addr               <= '0;
            r_len                <= '0;
            r_beat               <= '0;
            r_data_en            <= 1'b0;
            axi_slave_ar_ready_o <= 1'b0;
            axi_slave_r_valid_o  <= 1'b0;
            axi_slave_r_resp_o   <= RESP_OKAY;
            axi_slave_r_last_o   <= 1'b0;
            axi_slave_r_id_o     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_slave_ar_valid_i && axi_slave_ar_ready_o) begin
                        r_addr               <= axi_slave_ar_addr_i;
                        r_len                <= axi_slave_ar_len_i;
                        r_beat               <= '0;
                        axi_slave_r_id_o     <= axi_slave_ar_id_i;
                        axi_slave_ar_ready_o <= 1'b0;
                        r_state              <= R_FETCH;
                    end else begin
                        axi_slave_ar_ready_o <= 1'b1;
                    end
                end
                R_FETCH: begin
                    axi_slave_r_valid_o <= 1'b1;
                    axi_slave_r_last_o  <= (r_beat == r_len);
                    axi_slave_r_resp_o  <= out_of_range(r_addr) ? RESP_DECERR : RESP_OKAY;
                    r_data_en           <= ~out_of_range(r_addr);
                    r_state             <= R_DATA;
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (axi_slave_r_last_o) begin
                            axi_slave_r_valid_o  <= 1'b0;
                            axi_slave_r_last_o   <= 1'b0;
                            axi_slave_r_resp_o   <= RESP_OKAY;
                            r_data_en            <= 1'b0;
                            axi_slave_ar_ready_o <= 1'b1;
                            r_state              <= R_IDLE;
                        end else begin
                            r_addr <= r_addr_nxt;
                            r_beat <= r_beat_nxt;
`ifdef AXI_MEM_RESPONDER_PREFETCH_EN
                            axi_slave_r_last_o <= (r_beat_nxt == r_len);
                            axi_slave_r_resp_o <= out_of_range(r_addr_nxt) ? RESP_DECERR : RESP_OKAY;
                            r_data_en          <= ~out_of_range(r_addr_nxt);
`else
                            axi_slave_r_valid_o <= 1'b0;
                            r_data_en           <= 1'b0;
                            r_state             <= R_FETCH;
`endif
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_mem_bank #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (clk_i),
        .wr_en   (bank_wr_en),
        .wr_addr (word_idx(w_addr)),
        .wr_strb (axi_slave_w_strb_i),
        .wr_data (axi_slave_w_data_i),
        .rd_en   (bank_rd_en),
        .rd_addr (bank_rd_addr),
        .rd_data (bank_rd_data)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder
//   Directed bench for axi_mem_responder with default parameters
//   (32-bit address, 64-bit data, 3-bit ID, 1024 words).
module tb_axi_mem_responder;

`ifdef AXI_MEM_RESPONDER_PREFETCH_EN
    localparam int EXP_SPAN = 8;
`else
    localparam int EXP_SPAN = 15;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        aw_valid;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_id;
    logic        aw_ready;
    logic        w_valid;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic        b_ready;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_id;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic        r_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    axi_mem_responder dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .axi_slave_aw_valid_i (aw_valid),
        .axi_slave_aw_addr_i  (aw_addr),
        .axi_slave_aw_len_i   (aw_len),
        .axi_slave_aw_id_i    (aw_id),
        .axi_slave_aw_ready_o (aw_ready),
        .axi_slave_w_valid_i  (w_valid),
        .axi_slave_w_data_i   (w_data),
        .axi_slave_w_strb_i   (w_strb),
        .axi_slave_w_last_i   (w_last),
        .axi_slave_w_ready_o  (w_ready),
        .axi_slave_b_valid_o  (b_valid),
        .axi_slave_b_resp_o   (b_resp),
        .axi_slave_b_id_o     (b_id),
        .axi_slave_b_ready_i  (b_ready),
        .axi_slave_ar_valid_i (ar_valid),
        .axi_slave_ar_addr_i  (ar_addr),
        .axi_slave_ar_len_i   (ar_len),
        .axi_slave_ar_id_i    (ar_id),
        .axi_slave_ar_ready_o (ar_ready),
        .axi_slave_r_valid_o  (r_valid),
        .axi_slave_r_data_o   (r_data),
        .axi_slave_r_resp_o   (r_resp),
        .axi_slave_r_last_o   (r_last),
        .axi_slave_r_id_o     (r_id),
        .axi_slave_r_ready_i  (r_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id);
        int n = 0;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id;
        while (aw_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("aw_accept", 64'(aw_ready), 64'd1);
        step();
        aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
        while (w_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("w_accept", 64'(w_ready), 64'd1);
        step();
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic b_get(input logic [1:0] exp_resp, input logic [2:0] exp_id);
        int n = 0;
        b_ready = 1'b1;
        while (b_valid !== 1'b1 && n < 50) begin step(); n++; end
        check("b_valid", 64'(b_valid), 64'd1);
        check("b_resp", 64'(b_resp), 64'(exp_resp));
        check("b_id", 64'(b_id), 64'(exp_id));
        step();
        b_ready = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id);
        int n = 0;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_id = id;
        while (ar_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("ar_accept", 64'(ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
    endtask

    task automatic r_get(input string tag, input logic [63:0] exp_data, input logic [1:0] exp_resp,
                         input logic exp_last, input logic [2:0] exp_id);
        int n = 0;
        r_ready = 1'b1;
        while (r_valid !== 1'b1 && n < 50) begin step(); n++; end
        check({tag, "_valid"}, 64'(r_valid), 64'd1);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_resp"}, 64'(r_resp), 64'(exp_resp));
        check({tag, "_last"}, 64'(r_last), 64'(exp_last));
        check({tag, "_id"}, 64'(r_id), 64'(exp_id));
        step();
        r_ready = 1'b0;
    endtask

    task automatic wr_single(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input logic [2:0] id, input logic [1:0] exp_resp);
        aw_send(addr, 8'd0, id);
        w_send(data, strb, 1'b1);
        b_get(exp_resp, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int span;
        int beat;

        rst_i = 1'b1;
        aw_valid = 1'b1; aw_addr = 32'h40; aw_len = 8'd0; aw_id = 3'd1;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
        b_ready = 1'b0;
        ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_id = '0;
        r_ready = 1'b0;

        // Reset held three cycles with aw_valid asserted
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_aw_ready", 64'(aw_ready), 64'd0);
            check("rst_ar_ready", 64'(ar_ready), 64'd0);
            check("rst_valids", 64'({w_ready, b_valid, r_valid, r_last}), 64'd0);
        end
        check("rst_b_resp_id", 64'({b_resp, b_id}), 64'd0);
        check("rst_r_fields", 64'({r_resp, r_id}) | r_data, 64'd0);
        rst_i = 1'b0;
        aw_valid = 1'b0;
        check("rel_aw_ready_low", 64'(aw_ready), 64'd0);
        step();
        check("rel_aw_ready", 64'(aw_ready), 64'd1);
        check("rel_ar_ready", 64'(ar_ready), 64'd1);
        check("rel_no_hs", 64'(w_ready), 64'd0);

        // Four-beat burst write then read-back
        aw_send(32'h100, 8'd3, 3'd5);
        w_send(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        w_send(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        w_send(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
        w_send(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
        check("b_valid_next_cycle", 64'(b_valid), 64'd1);
        b_get(2'b00, 3'd5);

        ar_send(32'h100, 8'd3, 3'd2);
        check("r_lat_fetch", 64'(r_valid), 64'd0);
        step();
        check("r_lat_data", 64'(r_valid), 64'd1);
        r_get("burst_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 3'd2);
        r_get("burst_b1", 64'h2222_2222_2222_2222, 2'b00, 1'b0, 3'd2);
        r_get("burst_b2", 64'h3333_3333_3333_3333, 2'b00, 1'b0, 3'd2);
        r_get("burst_b3", 64'h4444_4444_4444_4444, 2'b00, 1'b1, 3'd2);

        // Byte strobes
        wr_single(32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd1, 2'b00);
        wr_single(32'h0, 64'h0, 8'h0F, 3'd1, 2'b00);
        ar_send(32'h0, 8'd0, 3'd3);
        r_get("strb", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 3'd3);

        // Out-of-range write and read (address aliases word 0 if truncated)
        wr_single(32'h2000, 64'h5555_5555_5555_5555, 8'hFF, 3'd6, 2'b11);
        ar_send(32'h0, 8'd0, 3'd3);
        r_get("oor_unchanged", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 3'd3);
        ar_send(32'h2000, 8'd0, 3'd7);
        r_get("oor_read", 64'h0, 2'b11, 1'b1, 3'd7);

        // DECERR takes priority over an early last
        aw_send(32'h2000, 8'd1, 3'd4);
        w_send(64'h1, 8'hFF, 1'b1);
        b_get(2'b11, 3'd4);

        // Early w_last: two of four beats sent
        wr_single(32'h210, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 3'd0, 2'b00);
        aw_send(32'h200, 8'd3, 3'd2);
        w_send(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
        w_send(64'h0202_0202_0202_0202, 8'hFF, 1'b1);
        b_get(2'b10, 3'd2);
        ar_send(32'h200, 8'd2, 3'd1);
        r_get("early_b0", 64'h0101_0101_0101_0101, 2'b00, 1'b0, 3'd1);
        r_get("early_b1", 64'h0202_0202_0202_0202, 2'b00, 1'b0, 3'd1);
        r_get("early_b2", 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, 1'b1, 3'd1);

        // Missing w_last at len: extra beat dropped
        wr_single(32'h310, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 3'd0, 2'b00);
        aw_send(32'h300, 8'd1, 3'd3);
        w_send(64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, 1'b0);
        w_send(64'h0B0B_0B0B_0B0B_0B0B, 8'hFF, 1'b0);
        w_send(64'h0C0C_0C0C_0C0C_0C0C, 8'hFF, 1'b1);
        b_get(2'b10, 3'd3);
        ar_send(32'h300, 8'd2, 3'd5);
        r_get("late_b0", 64'h0A0A_0A0A_0A0A_0A0A, 2'b00, 1'b0, 3'd5);
        r_get("late_b1", 64'h0B0B_0B0B_0B0B_0B0B, 2'b00, 1'b0, 3'd5);
        r_get("late_b2", 64'hBBBB_BBBB_BBBB_BBBB, 2'b00, 1'b1, 3'd5);

        // Back-pressure on r_ready
        ar_send(32'h100, 8'd3, 3'd4);
        n = 0;
        while (r_valid !== 1'b1 && n < 50) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            check("stall0_valid", 64'(r_valid), 64'd1);
            check("stall0_data", r_data, 64'h1111_1111_1111_1111);
            check("stall0_last", 64'(r_last), 64'd0);
            step();
        end
        r_get("stall_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 3'd4);
        r_get("stall_b1", 64'h2222_2222_2222_2222, 2'b00, 1'b0, 3'd4);
        r_get("stall_b2", 64'h3333_3333_3333_3333, 2'b00, 1'b0, 3'd4);
        n = 0;
        while (r_valid !== 1'b1 && n < 50) begin step(); n++; end
        for (int i = 0; i < 3; i++) begin
            check("stall3_data", r_data, 64'h4444_4444_4444_4444);
            check("stall3_last", 64'(r_last), 64'd1);
            step();
        end
        r_get("stall_b3", 64'h4444_4444_4444_4444, 2'b00, 1'b1, 3'd4);

        // Eight-beat read with r_ready held high: throughput
        aw_send(32'h400, 8'd7, 3'd6);
        for (int i = 0; i < 8; i++) begin
            w_send(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
        end
        b_get(2'b00, 3'd6);
        ar_send(32'h400, 8'd7, 3'd6);
        r_ready = 1'b1;
        n = 0;
        while (r_valid !== 1'b1 && n < 50) begin step(); n++; end
        span = 0;
        beat = 0;
        while (beat < 8 && span < 60) begin
            span++;
            if (r_valid === 1'b1) begin
                check("perf_data", r_data, 64'hC0DE_0000_0000_0000 + 64'(beat));
                check("perf_last", 64'(r_last), 64'(beat == 7));
                beat++;
            end
            if (beat < 8) step();
        end
        check("perf_beats", 64'(beat), 64'd8);
        check("perf_span", 64'(span), 64'(EXP_SPAN));
        step();
        r_ready = 1'b0;
        check("perf_idle", 64'(r_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
